// File: rtl/buscador_sar.sv
// Successive-approximation searcher: drives a trial value into a magnitude
// comparator and converges MSB-first on the hidden operand, exiting early on equality.
module buscador_sar #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             menor,
  input  logic             igual,
  input  logic             mayor,
  output logic [WIDTH-1:0] prueba,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             error
);

  localparam int              IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1'b1);
  localparam logic [IW-1:0]    MSB_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } estado_t;

  estado_t          estado_r, estado_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [WIDTH-1:0] prueba_r, prueba_s;
  logic [WIDTH-1:0] resultado_r, resultado_s;
  logic             error_r, error_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] bit_s, kept_s;
  logic             flags_ok_s;

  // A healthy comparator asserts exactly one of its three flags.
  function automatic logic es_onehot(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r <= ST_IDLE;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next-state logic
  always_comb begin
    flags_ok_s = es_onehot(menor, igual, mayor);
    estado_s   = estado_r;
    case (estado_r)
      ST_IDLE: begin
        if (start) estado_s = ST_PROBE;
        else       estado_s = ST_IDLE;
      end
      ST_PROBE: begin
        if (!flags_ok_s || igual || (idx_r == {IW{1'b0}})) estado_s = ST_DONE;
        else                                               estado_s = ST_PROBE;
      end
      ST_DONE: estado_s = ST_IDLE;
      default: estado_s = ST_IDLE;
    endcase
  end

  // Output / datapath next values; prueba keeps its last trial once the search ends
  always_comb begin
    idx_s       = idx_r;
    prueba_s    = prueba_r;
    resultado_s = resultado_r;
    error_s     = error_r;
    bit_s       = ONE_W << idx_r;
    kept_s      = mayor ? prueba_r : (prueba_r & ~bit_s);
    case (estado_r)
      ST_IDLE: begin
        if (start) begin
          idx_s       = MSB_IDX;
          prueba_s    = ONE_W << MSB_IDX;
          resultado_s = {WIDTH{1'b0}};
          error_s     = 1'b0;
        end else begin
          idx_s = idx_r;
        end
      end
      ST_PROBE: begin
        if (!flags_ok_s) begin
          error_s     = 1'b1;
          resultado_s = {WIDTH{1'b0}};
        end else if (igual) begin
          resultado_s = prueba_r;
        end else if (idx_r == {IW{1'b0}}) begin
          resultado_s = kept_s;
        end else begin
          idx_s    = idx_r - IW'(1);
          prueba_s = kept_s | (ONE_W << (idx_r - IW'(1)));
        end
      end
      ST_DONE: idx_s = MSB_IDX;
      default: idx_s = MSB_IDX;
    endcase
    busy_s = (estado_s == ST_PROBE);
    done_s = (estado_s == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= MSB_IDX;
      prueba_r    <= {WIDTH{1'b0}};
      resultado_r <= {WIDTH{1'b0}};
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      idx_r       <= idx_s;
      prueba_r    <= prueba_s;
      resultado_r <= resultado_s;
      error_r     <= error_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign prueba    = prueba_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign resultado = resultado_r;
  assign error     = error_r;

endmodule

// File: tb/tb_buscador_sar.sv
// Scoreboard bench for buscador_sar: a behavioural comparator holds A, expected
// trial sequences and results are queued at start and checked by a monitor.
module tb_buscador_sar;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         menor, igual, mayor;
  logic [W-1:0] prueba, resultado;
  logic         busy, done, error;
  logic [W-1:0] a_val = 4'd0;
  logic         force_bad = 1'b0;
  logic         mon_en = 1'b1;

  int tests = 0;
  int failed = 0;

  typedef struct {
    int res;
    int err;
    int n;
  } exp_t;

  int   probe_q[$];
  exp_t res_q[$];

  buscador_sar #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .menor(menor), .igual(igual), .mayor(mayor),
    .prueba(prueba), .busy(busy), .done(done),
    .resultado(resultado), .error(error)
  );

  // Comparator with A set by the bench; force_bad raises menor and mayor together
  assign menor = force_bad ? 1'b1 : (a_val < prueba);
  assign igual = force_bad ? 1'b0 : (a_val == prueba);
  assign mayor = force_bad ? 1'b1 : (a_val > prueba);

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: trial k keeps A's bits above idx and sets bit idx; search stops
  // at A's lowest set bit (equality) or after all WIDTH bits.
  task automatic push_expected(input int a, input bit bad);
    exp_t e;
    int   n, tz, idx, p;
    if (bad) begin
      probe_q.push_back(1 << (W - 1));
      e.res = 0; e.err = 1; e.n = 1;
    end else begin
      if (a == 0) n = W;
      else begin
        tz = 0;
        while (((a >> tz) & 1) == 0) tz++;
        n = W - tz;
      end
      for (int i = 0; i < n; i++) begin
        idx = W - 1 - i;
        p = (a / (1 << (idx + 1))) * (1 << (idx + 1)) + (1 << idx);
        probe_q.push_back(p);
      end
      e.res = a; e.err = 0; e.n = n;
    end
    res_q.push_back(e);
  endtask

  task automatic run_search(input int a, input bit bad, input bit hold);
    int k;
    a_val = a[W-1:0];
    @(negedge clk);
    push_expected(a, bad);
    start = 1'b1;
    force_bad = bad;
    @(negedge clk);
    if (!hold) start = 1'b0;
    @(negedge clk);
    #1;
    force_bad = 1'b0;
    k = 0;
    while (res_q.size() != 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    if (res_q.size() != 0) begin
      check("timeout_done", 0, 1);
      res_q.delete();
      probe_q.delete();
    end
    repeat (2) @(negedge clk);
    check("hold_resultado", int'(resultado), bad ? 0 : a);
    check("hold_busy", int'(busy), 0);
  endtask

  // Monitor: checks every probe cycle and every done pulse against the queues
  int  busy_cnt = 0;
  int  last_prueba = 0;
  bit  prev_busy = 1'b0;
  bit  prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mon_en) begin
      if (busy) begin
        if (probe_q.size() == 0) check("probe_unexpected", int'(prueba), -1);
        else check("prueba", int'(prueba), probe_q.pop_front());
        busy_cnt++;
        last_prueba = int'(prueba);
      end
      if (done) begin
        if (res_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = res_q.pop_front();
          check("resultado", int'(resultado), e.res);
          check("error", int'(error), e.err);
          check("busy_cycles", busy_cnt, e.n);
          check("done_after_busy", int'(prev_busy), 1);
          check("busy_at_done", int'(busy), 0);
          check("prueba_held", int'(prueba), last_prueba);
        end
        busy_cnt = 0;
      end
      if (done && prev_done) check("done_one_cycle", 1, 0);
      prev_busy = busy;
      prev_done = done;
    end else begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end
  end

  initial begin
    #3;
    check("rst_prueba", int'(prueba), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_resultado", int'(resultado), 0);
    check("rst_error", int'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_search(5, 1'b0, 1'b0);
    run_search(8, 1'b0, 1'b0);
    run_search(0, 1'b0, 1'b0);
    run_search(15, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) run_search(a, 1'b0, 1'b0);

    // Bad flags, then a clean search must clear error
    run_search(3, 1'b1, 1'b0);
    check("error_held", int'(error), 1);
    run_search(3, 1'b0, 1'b0);

    // start held through PROBE and DONE must not restart the search
    run_search(5, 1'b0, 1'b1);
    run_search(0, 1'b0, 1'b1);

    // Asynchronous reset during the second probe
    mon_en = 1'b0;
    a_val = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy_before_rst", int'(busy), 1);
    check("mid_prueba_before_rst", int'(prueba), 4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_prueba", int'(prueba), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_resultado", int'(resultado), 0);
    check("mid_rst_error", int'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle_busy", int'(busy), 0);
    check("post_rst_idle_done", int'(done), 0);
    mon_en = 1'b1;

    for (int i = 0; i < 20; i++) run_search(int'($urandom_range(15)), 1'b0, ($urandom_range(1) == 1));

    check("queues_drained", probe_q.size() + res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
